// File: rtl/johnson_decoder.sv
// -----------------------------------------------------------------------------
// johnson_decoder
//
// Receive-side monitor for a WIDTH-bit Johnson (twisted-ring) counter code in
// shift-left form: next = {cur[WIDTH-2:0], ~cur[WIDTH-1]}. Each valid sample
// is decoded to a phase index in 0..2*WIDTH-1 and checked two ways:
//   - code_err: the word is not one of the 2*WIDTH legal Johnson words
//   - seq_err : the word is legal but is not the successor of the previous
//               legal word (modulo 2*WIDTH)
// A HUNT/CHECK/LOCKED state machine tracks link health, and an 8-bit
// saturating counter accumulates error events.
//
// Ports
//   clk      in   rising-edge system clock
//   rst      in   asynchronous, active-low reset
//   code_in  in   [WIDTH-1:0] Johnson code word under test
//   code_vld in   code_in is sampled on cycles where this is high
//   index    out  [IDXW-1:0] decoded phase index (held between samples)
//   idx_vld  out  one-cycle pulse, code_vld delayed by one cycle
//   code_err out  sampled word was illegal (held between samples)
//   seq_err  out  sampled word was legal but out of order (held)
//   locked   out  state machine is in LOCKED
//   err_cnt  out  [7:0] saturating count of code_err/seq_err samples
// -----------------------------------------------------------------------------
module johnson_decoder #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 2,
  // Derived from WIDTH; leave at its default.
  parameter int unsigned IDXW       = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] code_in,
  input  logic             code_vld,
  output logic [IDXW-1:0]  index,
  output logic             idx_vld,
  output logic             code_err,
  output logic             seq_err,
  output logic             locked,
  output logic [7:0]       err_cnt
);

  localparam int unsigned NumStates = 2 * WIDTH;
  // Wide enough for a popcount (0..WIDTH) and a transition count (0..WIDTH-1).
  localparam int unsigned PopW      = $clog2(WIDTH + 1);
  localparam int unsigned GoodW     = $clog2(LOCK_CNT + 1);
  localparam int unsigned BadW      = $clog2(UNLOCK_CNT + 1);

  localparam logic [IDXW-1:0]  LastIdx  = IDXW'(NumStates - 1);
  localparam logic [GoodW-1:0] GoodGoal = GoodW'(LOCK_CNT);
  localparam logic [BadW-1:0]  BadGoal  = BadW'(UNLOCK_CNT);
  localparam logic [7:0]       CntMax   = 8'hFF;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StCheck  = 2'd1,
    StLocked = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  state_e           r_state;
  logic [GoodW-1:0] r_good_run;
  logic [BadW-1:0]  r_bad_run;
  logic             r_have_prev;
  logic [IDXW-1:0]  r_prev_idx;

  logic [IDXW-1:0]  r_index;
  logic             r_idx_vld;
  logic             r_code_err;
  logic             r_seq_err;
  logic             r_locked;
  logic [7:0]       r_err_cnt;

  // ---------------------------------------------------------------------------
  // Combinational decode of the current sample
  // ---------------------------------------------------------------------------
  logic [PopW-1:0]  w_pop;
  logic [PopW-1:0]  w_trans;
  logic             w_legal;
  logic [IDXW-1:0]  w_index;
  logic [IDXW-1:0]  w_expect;
  logic             w_seq_err;
  logic             w_err;
  logic [GoodW-1:0] w_good_inc;
  logic [BadW-1:0]  w_bad_inc;

  always_comb begin
    w_pop   = '0;
    w_trans = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + PopW'(code_in[i]);
    end
    // A Johnson word is a single run of ones and a single run of zeros, so it
    // has at most one place where adjacent bits differ.
    for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
      w_trans = w_trans + PopW'(code_in[i] ^ code_in[i+1]);
    end
  end

  assign w_legal = (w_trans <= PopW'(1));

  // First half of the cycle fills with ones from the LSB (MSB still 0), second
  // half drains them from the LSB (MSB is 1), hence the two branches.
  always_comb begin
    w_index = '0;
    if (code_in[WIDTH-1]) begin
      w_index = IDXW'(NumStates - 32'(w_pop));
    end else begin
      w_index = IDXW'(w_pop);
    end
  end

  // Expected successor with explicit wrap, since 2*WIDTH need not be a power
  // of two.
  assign w_expect   = (r_prev_idx == LastIdx) ? '0 : r_prev_idx + IDXW'(1);
  assign w_seq_err  = w_legal & r_have_prev & (w_index != w_expect);
  assign w_err      = ~w_legal | w_seq_err;
  assign w_good_inc = r_good_run + GoodW'(1);
  assign w_bad_inc  = r_bad_run + BadW'(1);

  // ---------------------------------------------------------------------------
  // Sample registers, sequence checker, error counter and lock FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StHunt;
      r_good_run  <= '0;
      r_bad_run   <= '0;
      r_have_prev <= 1'b0;
      r_prev_idx  <= '0;
      r_index     <= '0;
      r_idx_vld   <= 1'b0;
      r_code_err  <= 1'b0;
      r_seq_err   <= 1'b0;
      r_locked    <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_idx_vld <= code_vld;

      if (code_vld) begin
        // Decode result is published even for illegal words; code_err tells
        // the consumer to ignore it.
        r_index    <= w_index;
        r_code_err <= ~w_legal;
        r_seq_err  <= w_seq_err;

        // Illegal words never become the reference; legal ones always do, so
        // the checker resynchronises after a single out-of-order step.
        if (w_legal) begin
          r_prev_idx  <= w_index;
          r_have_prev <= 1'b1;
        end

        if (w_err && (r_err_cnt != CntMax)) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end

        unique case (r_state)
          StHunt: begin
            if (w_legal) begin
              r_state    <= StCheck;
              r_good_run <= '0;
            end
          end

          StCheck: begin
            if (w_err) begin
              r_state    <= StHunt;
              r_good_run <= '0;
            end else if (w_good_inc == GoodGoal) begin
              r_state    <= StLocked;
              r_good_run <= '0;
              r_bad_run  <= '0;
              r_locked   <= 1'b1;
            end else begin
              r_good_run <= w_good_inc;
            end
          end

          StLocked: begin
            if (w_err) begin
              if (w_bad_inc == BadGoal) begin
                r_state    <= StHunt;
                r_bad_run  <= '0;
                r_good_run <= '0;
                r_locked   <= 1'b0;
              end else begin
                r_bad_run <= w_bad_inc;
              end
            end else begin
              r_bad_run <= '0;
            end
          end

          default: begin
            r_state    <= StHunt;
            r_good_run <= '0;
            r_bad_run  <= '0;
            r_locked   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign index    = r_index;
  assign idx_vld  = r_idx_vld;
  assign code_err = r_code_err;
  assign seq_err  = r_seq_err;
  assign locked   = r_locked;
  assign err_cnt  = r_err_cnt;

endmodule
